// File: rtl/hs_pkg.sv
// Shared definitions for the two-phase toggle handshake (rx and tx sides).
package hs_pkg;
    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int DATA_W_DEF      = 8;
endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser with synchronous reset to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/toggle_hs_rx.sv
// Receive side of the toggle handshake: detects req_tgl edges, captures the
// word, presents it valid/ready and returns ack_tgl once consumed.
module toggle_hs_rx
    import hs_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    input  logic              ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              proto_err
);
    state_t state, state_nx;
    logic   req_sync, req_seen, pending;
    logic   capture, done;

    bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_sync)
    );

    assign pending = req_sync ^ req_seen;
    assign valid   = (state == FULL);

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (pending) begin
                capture  = 1'b1;
                state_nx = FULL;
            end
            FULL: if (ready) begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_seen  <= 1'b0;
            ack_tgl   <= 1'b0;
            data_out  <= '0;
            xfer_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (capture) begin
                data_out <= data_in;
                req_seen <= req_sync;
            end
            if (done) begin
                ack_tgl  <= ~ack_tgl;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            // An edge arriving while a word is still held: the sender skipped the ack.
            // req_seen is left alone so that edge becomes the next word.
            if (state == FULL && pending)
                proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_toggle_hs_rx.sv
// Directed self-checking bench for toggle_hs_rx (counter narrowed to 4 bits).
module tb_toggle_hs_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_tgl;
    logic [7:0] data_in;
    logic       ack_tgl;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic [3:0] xfer_cnt;
    logic       proto_err;

    int checks = 0;
    int errors = 0;

    toggle_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_tgl   (req_tgl),
        .data_in   (data_in),
        .ack_tgl   (ack_tgl),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .xfer_cnt  (xfer_cnt),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_tgl = 1'b0; data_in = 8'h00; ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Sender model: flips req_tgl with word w, holds ready high, waits for valid then ack flip.
    task automatic send_word(input logic [7:0] w, output logic [7:0] got, output bit to);
        logic a0;
        a0 = ack_tgl;
        data_in = w;
        req_tgl = ~req_tgl;
        ready = 1'b1;
        to = 1'b1;
        got = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) begin got = data_out; to = 1'b0; break; end
        end
        if (!to) begin
            to = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (ack_tgl !== a0) begin to = 1'b0; break; end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_tgl = 1'b1; data_in = 8'hFF; ready = 1'b0;
        tick(); tick();
        checks++; if (ack_tgl !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_tgl); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
        checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", xfer_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", proto_err); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_early_valid: got %b want 0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || data_out !== 8'hFF) begin
            errors++; $display("FAIL reset_post_word: valid=%b data=%h want 1/ff", valid, data_out);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        data_in = 8'hA5; ready = 1'b1;
        req_tgl = 1'b1;
        tick(); tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", valid); end
        tick();
        checks++; if (valid !== 1'b1 || data_out !== 8'hA5) begin
            errors++; $display("FAIL single_word: valid=%b data=%h want 1/a5", valid, data_out);
        end
        tick();
        checks++; if (valid !== 1'b0 || ack_tgl !== 1'b1 || xfer_cnt !== 4'd1) begin
            errors++; $display("FAIL single_done: valid=%b ack=%b cnt=%0d want 0/1/1", valid, ack_tgl, xfer_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit bad;
        do_reset();
        data_in = 8'hA5; ready = 1'b0;
        req_tgl = 1'b1;
        tick(); tick(); tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", valid); end
        data_in = 8'h00;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid !== 1'b1 || data_out !== 8'hA5 || ack_tgl !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin
            errors++; $display("FAIL bp_hold: valid=%b data=%h ack=%b want 1/a5/0", valid, data_out, ack_tgl);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (ack_tgl !== 1'b1 || xfer_cnt !== 4'd1 || valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: ack=%b cnt=%0d valid=%b want 1/1/0", ack_tgl, xfer_cnt, valid);
        end
        tick(); tick();
        checks++; if (xfer_cnt !== 4'd1) begin errors++; $display("FAIL bp_single_inc: got %0d want 1", xfer_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        bit to;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send_word(8'(i), got, to);
            checks++; if (to || got !== 8'(i)) begin
                errors++; $display("FAIL b2b_word%0d: got %h timeout=%0d want %h", i, got, to, 8'(i));
            end
        end
        checks++; if (ack_tgl !== 1'b1 || xfer_cnt !== 4'd5 || proto_err !== 1'b0) begin
            errors++; $display("FAIL b2b_end: ack=%b cnt=%0d perr=%b want 1/5/0", ack_tgl, xfer_cnt, proto_err);
        end
    endtask

    task automatic test_proto_err();
        bit seen;
        do_reset();
        data_in = 8'h11; ready = 1'b0;
        req_tgl = 1'b1;
        tick(); tick(); tick();
        checks++; if (valid !== 1'b1 || proto_err !== 1'b0) begin
            errors++; $display("FAIL perr_first: valid=%b perr=%b want 1/0", valid, proto_err);
        end
        data_in = 8'h22;
        req_tgl = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (proto_err === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL perr_raise: got %b want 1", proto_err); end
        tick(); tick();
        checks++; if (proto_err !== 1'b1 || data_out !== 8'h11) begin
            errors++; $display("FAIL perr_hold: perr=%b data=%h want 1/11", proto_err, data_out);
        end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b0 || ack_tgl !== 1'b1) begin
            errors++; $display("FAIL perr_consume: valid=%b ack=%b want 0/1", valid, ack_tgl);
        end
        tick();
        checks++; if (valid !== 1'b1 || data_out !== 8'h22) begin
            errors++; $display("FAIL perr_second: valid=%b data=%h want 1/22", valid, data_out);
        end
        tick();
        checks++; if (xfer_cnt !== 4'd2 || proto_err !== 1'b1 || ack_tgl !== 1'b0) begin
            errors++; $display("FAIL perr_end: cnt=%0d perr=%b ack=%b want 2/1/0", xfer_cnt, proto_err, ack_tgl);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [7:0] got;
        bit to, any_to;
        do_reset();
        any_to = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_word(8'(i + 8'h40), got, to);
            if (to) any_to = 1'b1;
        end
        checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d want 0", xfer_cnt); end
        send_word(8'h99, got, to);
        if (to) any_to = 1'b1;
        checks++; if (any_to || xfer_cnt !== 4'd1) begin
            errors++; $display("FAIL wrap_17: cnt=%0d timeout=%0d want 1/0", xfer_cnt, any_to);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_proto_err();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/toggle_hs_rx.md
Name: toggle_hs_rx

Overview:
- Receiving end of the team's two-phase (toggle) handshake.
- The sender flips req_tgl once per word, using a T-flop driven by a send pulse, and holds data_in stable until it sees ack_tgl flip.
- This block synchronises req_tgl, detects each toggle, captures the word and presents it on a valid/ready interface. Once the word is consumed it flips ack_tgl back to the sender.
- Sits at clock-domain or block boundaries wherever a single-word toggle link terminates.

Parameters:
- DATA_W, 8, width of data_in/data_out.
- SYNC_STAGES, 2, flops in the req_tgl synchroniser chain (minimum 2).
- CNT_W, 16, width of the transfer counter (wraps).

Ports:
- clk  input  1  receive-side clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- req_tgl  input  1  request toggle from sender; may be asynchronous to clk.
- data_in  input  DATA_W  sender data; stable from the req_tgl flip until the matching ack_tgl flip.
- ack_tgl  output  1  acknowledge toggle to sender.
- data_out  output  DATA_W  captured word.
- valid  output  1  data_out holds an unconsumed word.
- ready  input  1  downstream accepts the word when valid && ready.
- xfer_cnt  output  CNT_W  count of completed transfers.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at posedge) clears all of the following to 0:
  - synchroniser flops and req_seen;
  - ack_tgl, valid, data_out, xfer_cnt, proto_err;
  - state, which goes to IDLE.
- Reset has priority over every other event.
- Synchroniser: req_sync = req_tgl after SYNC_STAGES flops. Edge detection: pending = req_sync ^ req_seen.
- FSM, two states:
  - IDLE: valid=0. If pending=1:
    - data_out <= data_in, req_seen <= req_sync, state <= FULL.
    - valid is asserted next cycle.
  - FULL: valid=1, data_out held.
    - On valid && ready: state <= IDLE, ack_tgl <= ~ack_tgl, xfer_cnt <= xfer_cnt+1 (wraps at 2^CNT_W-1 -> 0).
    - valid is 0 in the following cycle.
- Latency:
  - req_tgl flip to valid=1: SYNC_STAGES+1 clk cycles, i.e. 3 at default.
  - Handshake to ack_tgl flip: 1 cycle.
  - Minimum spacing between accepted words is SYNC_STAGES+2 cycles plus the sender round trip.
- ready with valid=0 is ignored. ready held high makes FULL last exactly 1 cycle.
- Protocol error:
  - Condition: pending=1 while in FULL, meaning the sender toggled again before ack.
  - Effect: proto_err <= 1, sticky until rst.
  - The word in data_out is kept and req_seen is not updated. The extra edge is therefore taken as a new word after the current one is consumed.
- Reset mid-transfer: the word is discarded and ack_tgl returns to 0. The sender must be reset in the same window so both toggles restart at 0. If req_tgl is still 1 after reset, one transfer is recognised.
- data_in is sampled only in the IDLE->FULL cycle. It is never sampled through the synchroniser; the sender's stability rule covers it.

Decomposition:
- Shared package (hs_pkg):
  - state enum {IDLE, FULL};
  - default constants SYNC_STAGES_DEF=2 and DATA_W_DEF=8, for reuse by the matching toggle_hs_tx.
- One sub-module: bit_sync (parameter STAGES, 1-bit in/out, synchronous reset to 0), instantiated for req_tgl.

Test Plan:
- Reset: rst=1 for 2 cycles with req_tgl=1, data_in=8'hFF -> ack_tgl=0, valid=0, data_out=0, xfer_cnt=0, proto_err=0. After rst drops, valid=1 on the 3rd cycle with data_out=8'hFF.
- Single word: data_in=8'hA5, flip req_tgl 0->1, ready=1:
  - valid=1 exactly 3 cycles later with data_out=8'hA5;
  - valid=0 the next cycle, ack_tgl=1, xfer_cnt=1.
- Backpressure: ready=0 for 10 cycles after valid rises, data_in changed to 8'h00 after ack wait -> data_out stays 8'hA5, ack_tgl unchanged. Then ready=1 for 1 cycle -> ack_tgl flips, xfer_cnt increments once.
- Back-to-back: a sender model toggles req_tgl on every ack flip for 5 words 8'h01..8'h05, ready=1 -> the 5 words appear in order, ack_tgl ends at 1, xfer_cnt=5, proto_err=0.
- Protocol error: while in FULL with ready=0, flip req_tgl again -> proto_err=1 within SYNC_STAGES+1 cycles and stays 1. After ready: the first word is delivered, then a second valid follows.
- Counter wrap (CNT_W=4): 17 transfers -> xfer_cnt=1.
